tm_clause_loader: RTL and testbench
===================================

Name: tm_clause_loader

Overview:
Upstream configuration stage for the Tsetlin inference datapath. It receives clause include/exclude literal masks as a framed nibble stream with a valid/ready handshake. It verifies each frame with an XOR checksum and commits the masks atomically to a packed clause bus. That bus drives the inference stage's eight 4-bit clause-mask inputs, replacing the hard-coded reset masks with runtime-loadable ones.

Parameters:
N_CLAUSE, 8, number of clause masks per frame
LIT_W, 4, literal mask width per clause (2 features x {pos,neg})

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
s_valid  input  1  stream beat valid
s_data  input  LIT_W  stream nibble (clause mask or checksum)
s_last  input  1  marks final beat of frame
s_ready  output  1  loader can accept a beat
clause_bus  output  N_CLAUSE*LIT_W  packed masks; clause k at bits [k*LIT_W +: LIT_W], k=0..N_CLAUSE-1
cfg_valid  output  1  clause_bus holds a committed configuration and no frame is in progress
cfg_update  output  1  one-cycle pulse on commit
cfg_err  output  1  sticky: last frame rejected
busy  output  1  frame in progress (LOAD/DRAIN/COMMIT)

Behaviour:
- Beat accepted on a rising clk edge when s_valid && s_ready.
- Frame format: N_CLAUSE mask beats (clause 0 first), then 1 checksum beat with s_last=1. Checksum = XOR of all mask nibbles.
- Reset (rst=0 at a clk edge) forces the following:
  - clause_bus = default masks, clause0..7 = C,9,C,6,5,C,1,3 (packed 32'h31C56C9C)
  - cfg_valid=1, cfg_update=0, cfg_err=0, busy=0, s_ready=1
  - state IDLE, beat counter 0, shadow 0, running XOR 0.
- FSM states: IDLE, LOAD, DRAIN, COMMIT.
- IDLE
  - s_ready=1.
  - Accepted beat with s_last=0: write shadow[0], XOR=s_data, cnt=1, enter LOAD. cfg_valid drops to 0 on the next cycle.
  - Accepted beat with s_last=1 (1-beat frame): error; set cfg_err=1, stay IDLE, cfg_valid stays 1.
- LOAD
  - s_ready=1.
  - Beat with cnt<N_CLAUSE and s_last=0: write shadow[cnt], XOR^=s_data, cnt++.
  - Beat with cnt<N_CLAUSE and s_last=1: early end. cfg_err=1, discard shadow, go IDLE.
  - Beat with cnt==N_CLAUSE and s_last=1: checksum beat. Compare s_data with the running XOR.
    - Match: go COMMIT.
    - Mismatch: cfg_err=1, go IDLE.
  - Beat with cnt==N_CLAUSE and s_last=0: overlong frame. cfg_err=1, go DRAIN.
- DRAIN
  - s_ready=1, discard beats until an accepted beat with s_last=1, then go IDLE.
- COMMIT (exactly 1 cycle)
  - s_ready=0; clause_bus<=shadow, cfg_update=1 for this cycle, cfg_err<=0, go IDLE.
  - Latency: clause_bus changes exactly 1 cycle after the checksum beat is accepted. cfg_update is coincident with the new value.
- clause_bus never changes except at reset or COMMIT. Rejected frames leave it untouched (no partial update).
- cfg_valid = 0 in LOAD/DRAIN/COMMIT, 1 in IDLE.
- busy = (state != IDLE).
- Beats with s_valid=0 are ignored: gaps of any length are legal, and no timeout applies.
- s_data/s_last are don't-care when s_valid=0.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values next cycle, including clause_bus back to the defaults.
- cnt width is clog2(N_CLAUSE+1). No wrap is possible; cnt saturates via the state transitions.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> clause_bus=32'h31C56C9C, cfg_valid=1, cfg_err=0, s_ready=1.
- Good frame:
  - Stimulus: nibbles 1,2,3,4,5,6,7,8 back-to-back, then checksum 8 with s_last.
  - Required: cfg_update pulses 1 cycle after the checksum beat; clause_bus=32'h87654321; cfg_valid=0 during the frame and 1 after; cfg_err=0.
- Bad checksum:
  - Stimulus: same frame with checksum 9.
  - Required: cfg_err=1; clause_bus unchanged (32'h31C56C9C); no cfg_update; then a good frame clears cfg_err and commits.
- Early s_last:
  - Stimulus: s_last on the 5th beat.
  - Required: cfg_err=1, return to IDLE, clause_bus unchanged. An overlong frame (10 beats, s_last on the 10th) -> DRAIN absorbs the remainder, cfg_err=1.
- Gapped stream:
  - Stimulus: random s_valid gaps (0-5 cycles) inside a good frame C,9,C,6,5,C,1,3 with checksum 4.
  - Required: commit to 32'h31C56C9C with a cfg_update pulse. s_ready=0 only in the COMMIT cycle.
- Reset mid-frame:
  - Stimulus: commit 32'h87654321, start a new frame, assert rst after 3 beats.
  - Required: clause_bus=32'h31C56C9C, busy=0, cfg_valid=1. A following good frame loads normally.

Source files
------------

// File: rtl/tm_clause_loader.sv
// Clause-mask loader: receives a framed nibble stream, verifies its XOR checksum and
// atomically commits the masks onto the packed clause bus used by the inference stage.
module tm_clause_loader #(
  parameter int N_CLAUSE = 8,
  parameter int LIT_W    = 4,
  parameter logic [N_CLAUSE*LIT_W-1:0] DEFAULT_MASKS = 32'h31C5_6C9C
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [LIT_W-1:0]          s_data,
  input  logic                      s_last,
  output logic                      s_ready,
  output logic [N_CLAUSE*LIT_W-1:0] clause_bus,
  output logic                      cfg_valid,
  output logic                      cfg_update,
  output logic                      cfg_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(N_CLAUSE + 1);
  localparam int BUS_W = N_CLAUSE * LIT_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Running checksum step: XOR accumulation of mask nibbles.
  function automatic logic [LIT_W-1:0] f_csum_step(input logic [LIT_W-1:0] acc,
                                                   input logic [LIT_W-1:0] nib);
    return acc ^ nib;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [LIT_W-1:0]   r_xor;
  logic [LIT_W-1:0]   w_xor_nxt;
  logic [BUS_W-1:0]   r_shadow;
  logic [BUS_W-1:0]   r_bus;
  logic               r_s_ready;
  logic               r_cfg_valid;
  logic               r_cfg_update;
  logic               r_cfg_err;
  logic               r_busy;
  logic               w_accept;
  logic               w_shadow_we;
  logic               w_err_set;
  logic               w_commit;

  assign w_accept = s_valid && r_s_ready;

  // Next-state, counter, checksum and event decode for the frame FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_xor_nxt   = r_xor;
    w_shadow_we = 1'b0;
    w_err_set   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (s_last) begin
            w_err_set = 1'b1;
          end else begin
            w_shadow_we = 1'b1;
            w_xor_nxt   = s_data;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (!w_accept) begin
          w_state_nxt = ST_LOAD;
        end else if (r_cnt < CNT_W'(N_CLAUSE)) begin
          if (s_last) begin
            w_err_set   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_shadow_we = 1'b1;
            w_xor_nxt   = f_csum_step(r_xor, s_data);
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end else if (s_last) begin
          w_cnt_nxt = '0;
          if (s_data == r_xor) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_COMMIT;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_err_set   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs; status follows the next state so
  // the bus, cfg_update and cleared error all appear together in the COMMIT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_xor        <= '0;
      r_bus        <= DEFAULT_MASKS;
      r_s_ready    <= 1'b1;
      r_cfg_valid  <= 1'b1;
      r_cfg_update <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_xor        <= w_xor_nxt;
      r_s_ready    <= (w_state_nxt != ST_COMMIT);
      r_cfg_valid  <= (w_state_nxt == ST_IDLE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_cfg_update <= w_commit;
      if (w_commit) begin
        r_bus     <= r_shadow;
        r_cfg_err <= 1'b0;
      end else if (w_err_set) begin
        r_bus     <= r_bus;
        r_cfg_err <= 1'b1;
      end else begin
        r_bus     <= r_bus;
        r_cfg_err <= r_cfg_err;
      end
    end
  end

  // Shadow mask store, one nibble per accepted mask beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow <= '0;
    end else begin
      for (int k = 0; k < N_CLAUSE; k++) begin
        if (w_shadow_we && (r_cnt == CNT_W'(k))) begin
          r_shadow[k*LIT_W +: LIT_W] <= s_data;
        end else begin
          r_shadow[k*LIT_W +: LIT_W] <= r_shadow[k*LIT_W +: LIT_W];
        end
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign clause_bus = r_bus;
  assign cfg_valid  = r_cfg_valid;
  assign cfg_update = r_cfg_update;
  assign cfg_err    = r_cfg_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_tm_clause_loader.sv
// Directed self-checking bench for tm_clause_loader: good/bad/short/long/gapped
// frames and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_tm_clause_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic [3:0]  s_data = 4'h0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] clause_bus;
  logic        cfg_valid;
  logic        cfg_update;
  logic        cfg_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  localparam logic [31:0] DEF_MASKS = 32'h31C56C9C;

  tm_clause_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .clause_bus(clause_bus), .cfg_valid(cfg_valid),
    .cfg_update(cfg_update), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count every cfg_update cycle seen at a clock edge.
  always @(posedge clk) if (cfg_update) upd_cnt <= upd_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one beat; wait (bounded) for s_ready, return #1 after the accepting edge.
  task automatic beat(input logic [3:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (s_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL beat_ready_timeout: s_ready=%b required 1", s_ready);
    end
    s_valid = 1'b1; s_data = d; s_last = l;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] m, input logic [3:0] cs);
    for (int k = 0; k < 8; k++) beat(m[k*4 +: 4], 1'b0);
    beat(cs, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (clause_bus !== DEF_MASKS) begin errors++; $display("FAIL reset_bus: got %h required %h", clause_bus, DEF_MASKS); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL reset_cfg_valid: got %b required 1", cfg_valid); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b required 0", cfg_err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    checks++; if (busy !== 1'b0 || cfg_update !== 1'b0) begin errors++; $display("FAIL reset_busy_upd: got %b%b required 00", busy, cfg_update); end
  endtask

  task automatic test_bad_checksum;
    int u0;
    u0 = upd_cnt;
    send_frame(32'h87654321, 4'h9);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL badcs_err: got %b required 1", cfg_err); end
    checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL badcs_update: got %b required 0", cfg_update); end
    checks++; if (busy !== 1'b0 || cfg_valid !== 1'b1) begin errors++; $display("FAIL badcs_idle: busy=%b cfg_valid=%b required 0/1", busy, cfg_valid); end
    @(posedge clk); #1;
    checks++; if (clause_bus !== DEF_MASKS) begin errors++; $display("FAIL badcs_bus: got %h required %h", clause_bus, DEF_MASKS); end
    checks++; if (upd_cnt != u0) begin errors++; $display("FAIL badcs_no_pulse: got %0d pulses required 0", upd_cnt - u0); end
  endtask

  task automatic test_good_frame;
    int u0;
    u0 = upd_cnt;
    beat(4'h1, 1'b0);
    checks++; if (cfg_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL good_in_frame: cfg_valid=%b busy=%b required 0/1", cfg_valid, busy); end
    for (int k = 2; k <= 8; k++) beat(4'(k), 1'b0);
    checks++; if (cfg_update !== 1'b0 || clause_bus !== DEF_MASKS) begin errors++; $display("FAIL good_before_cs: upd=%b bus=%h required 0/%h", cfg_update, clause_bus, DEF_MASKS); end
    beat(4'h8, 1'b1);
    checks++; if (cfg_update !== 1'b1) begin errors++; $display("FAIL good_update: got %b required 1", cfg_update); end
    checks++; if (clause_bus !== 32'h87654321) begin errors++; $display("FAIL good_bus: got %h required 87654321", clause_bus); end
    checks++; if (s_ready !== 1'b0 || cfg_valid !== 1'b0) begin errors++; $display("FAIL good_commit_cycle: s_ready=%b cfg_valid=%b required 0/0", s_ready, cfg_valid); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL good_err_clear: got %b required 0", cfg_err); end
    @(posedge clk); #1;
    checks++; if (cfg_update !== 1'b0 || cfg_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL good_after: upd=%b cfg_valid=%b busy=%b required 0/1/0", cfg_update, cfg_valid, busy); end
    checks++; if (upd_cnt != u0 + 1) begin errors++; $display("FAIL good_one_pulse: got %0d pulses required 1", upd_cnt - u0); end
  endtask

  task automatic test_one_beat;
    beat(4'h5, 1'b1);
    checks++; if (cfg_err !== 1'b1 || cfg_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL onebeat: err=%b cfg_valid=%b busy=%b required 1/1/0", cfg_err, cfg_valid, busy); end
    checks++; if (clause_bus !== 32'h87654321) begin errors++; $display("FAIL onebeat_bus: got %h required 87654321", clause_bus); end
  endtask

  task automatic test_early_last;
    send_frame(32'h87654321, 4'h8);
    @(posedge clk); #1;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL early_pre_clear: got %b required 0", cfg_err); end
    for (int k = 1; k <= 4; k++) beat(4'(k + 8), 1'b0);
    beat(4'hD, 1'b1);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg_valid !== 1'b1) begin errors++; $display("FAIL early_last: err=%b busy=%b cfg_valid=%b required 1/0/1", cfg_err, busy, cfg_valid); end
    checks++; if (clause_bus !== 32'h87654321) begin errors++; $display("FAIL early_bus: got %h required 87654321", clause_bus); end
  endtask

  task automatic test_overlong;
    int u0;
    send_frame(32'h87654321, 4'h8);
    @(posedge clk); #1;
    u0 = upd_cnt;
    for (int k = 1; k <= 8; k++) beat(4'(16 - k), 1'b0);
    beat(4'h9, 1'b0);
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b1 || cfg_valid !== 1'b0) begin errors++; $display("FAIL overlong_drain: err=%b busy=%b cfg_valid=%b required 1/1/0", cfg_err, busy, cfg_valid); end
    beat(4'hA, 1'b1);
    checks++; if (busy !== 1'b0 || cfg_valid !== 1'b1 || cfg_err !== 1'b1) begin errors++; $display("FAIL overlong_end: busy=%b cfg_valid=%b err=%b required 0/1/1", busy, cfg_valid, cfg_err); end
    @(posedge clk); #1;
    checks++; if (clause_bus !== 32'h87654321 || upd_cnt != u0) begin errors++; $display("FAIL overlong_bus: got %h pulses %0d required 87654321/0", clause_bus, upd_cnt - u0); end
  endtask

  task automatic test_gapped;
    logic [31:0] m;
    int gap;
    m = DEF_MASKS;
    for (int k = 0; k < 9; k++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL gap_ready: got %b required 1", s_ready); end
      end
      if (k < 8) beat(m[k*4 +: 4], 1'b0);
      else beat(4'h4, 1'b1);
    end
    checks++; if (cfg_update !== 1'b1 || clause_bus !== DEF_MASKS) begin errors++; $display("FAIL gapped_commit: upd=%b bus=%h required 1/%h", cfg_update, clause_bus, DEF_MASKS); end
    checks++; if (s_ready !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL gapped_commit_flags: s_ready=%b err=%b required 0/0", s_ready, cfg_err); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1 || cfg_update !== 1'b0) begin errors++; $display("FAIL gapped_after: s_ready=%b upd=%b required 1/0", s_ready, cfg_update); end
  endtask

  task automatic test_reset_midframe;
    send_frame(32'h87654321, 4'h8);
    checks++; if (clause_bus !== 32'h87654321) begin errors++; $display("FAIL mid_precommit: got %h required 87654321", clause_bus); end
    beat(4'h1, 1'b0); beat(4'h2, 1'b0); beat(4'h3, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (clause_bus !== DEF_MASKS) begin errors++; $display("FAIL mid_rst_bus: got %h required %h", clause_bus, DEF_MASKS); end
    checks++; if (busy !== 1'b0 || cfg_valid !== 1'b1 || s_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_flags: busy=%b cfg_valid=%b s_ready=%b required 0/1/1", busy, cfg_valid, s_ready); end
    @(negedge clk) rst = 1'b1;
    send_frame(32'h12345678, 4'h8);
    checks++; if (clause_bus !== 32'h12345678 || cfg_update !== 1'b1) begin errors++; $display("FAIL mid_reload: bus=%h upd=%b required 12345678/1", clause_bus, cfg_update); end
  endtask

  initial begin
    test_reset;
    test_bad_checksum;
    test_good_frame;
    test_one_beat;
    test_early_last;
    test_overlong;
    test_gapped;
    test_reset_midframe;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
